// File: rtl/light_pkg.sv
// Shared encodings for the traffic-light sequencer and its phase monitor.
// Lamp patterns are the raw active-low lines packed as {red_n, green_n, blue_n}.
package light_pkg;

    typedef enum logic [1:0] {
        PH_RED   = 2'd0,
        PH_BLUE  = 2'd1,
        PH_GREEN = 2'd2,
        PH_NONE  = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        FC_NONE    = 3'd0,
        FC_ILLEGAL = 3'd1,
        FC_BAD_SEQ = 3'd2,
        FC_SHORT   = 3'd3,
        FC_LONG    = 3'd4,
        FC_DARK    = 3'd5
    } fault_code_t;

    localparam logic [2:0] LAMP_RED   = 3'b011;
    localparam logic [2:0] LAMP_GREEN = 3'b101;
    localparam logic [2:0] LAMP_BLUE  = 3'b110;
    localparam logic [2:0] LAMP_DARK  = 3'b111;

    // Single-lamp patterns map to their phase; dark and multi-lamp give PH_NONE.
    function automatic phase_t lamp_phase(input logic [2:0] pat);
        case (pat)
            LAMP_RED:   return PH_RED;
            LAMP_BLUE:  return PH_BLUE;
            LAMP_GREEN: return PH_GREEN;
            default:    return PH_NONE;
        endcase
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_RED:   return PH_BLUE;
            PH_BLUE:  return PH_GREEN;
            PH_GREEN: return PH_RED;
            default:  return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/light_phase_monitor_if.sv
// Lamp lines, supervisor clear and monitor status bundled between sequencer side and monitor.
interface light_phase_monitor_if
    import light_pkg::*;
#(
    parameter int CNT_W = 28
) ();
    logic             red_n;
    logic             green_n;
    logic             blue_n;
    logic             clr_fault;
    phase_t           phase;
    logic             phase_valid;
    logic             phase_done;
    logic [CNT_W-1:0] last_dur;
    logic             fault;
    fault_code_t      fault_code;

    modport master (
        output red_n, green_n, blue_n, clr_fault,
        input  phase, phase_valid, phase_done, last_dur, fault, fault_code
    );

    modport slave (
        input  red_n, green_n, blue_n, clr_fault,
        output phase, phase_valid, phase_done, last_dur, fault, fault_code
    );
endinterface

// File: rtl/lamp_filter.sv
// Two-flop synchronizer plus stability filter on the packed lamp lines.
// pat is the accepted pattern as of this cycle; chg flags that it differs from last cycle.
module lamp_filter
    import light_pkg::*;
#(
    parameter int FILT_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] lamp_n,
    output logic [2:0] pat,
    output logic       chg
);
    localparam int RW = $clog2(FILT_CYC + 2);

    if (FILT_CYC < 1) begin : g_filt_chk
        $error("lamp_filter: FILT_CYC must be at least 1");
    end

    logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]    last_q, last_d, acc_q, acc_d;
    logic [RW-1:0] run_q, run_d, run_cur;

    // run_cur counts the current cycle, so a pattern is accepted on its FILT_CYC-th cycle.
    always_comb begin
        sync1_d = lamp_n;
        sync2_d = sync1_q;
        last_d  = sync2_q;
        run_cur = (sync2_q == last_q) ? run_q + 1'b1 : RW'(1);
        run_d   = (run_cur > RW'(FILT_CYC)) ? RW'(FILT_CYC) : run_cur;
        acc_d   = (run_cur >= RW'(FILT_CYC)) ? sync2_q : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= LAMP_DARK;
            sync2_q <= LAMP_DARK;
            last_q  <= LAMP_DARK;
            acc_q   <= LAMP_DARK;
            run_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            run_q   <= run_d;
        end
    end

    assign pat = acc_d;
    assign chg = (acc_d != acc_q);

endmodule

// File: rtl/light_phase_monitor.sv
// Phase monitor for the RED->BLUE->GREEN lamp sequence with sticky first-fault capture.
// Define LPM_DUR_CHECK_EN to include the SHORT/LONG phase duration checks.
module light_phase_monitor
    import light_pkg::*;
#(
    parameter int RED_CYC   = 240_000_000,
    parameter int BLUE_CYC  = 48_000_000,
    parameter int GREEN_CYC = 120_000_000,
    parameter int TOL_CYC   = 16,
    parameter int FILT_CYC  = 4,
    parameter int CNT_W     = 28
) (
    input  logic clk,
    input  logic rst_n,
    light_phase_monitor_if.slave bus
);
    typedef enum logic [2:0] {S_SYNC, S_RED, S_BLUE, S_GREEN, S_FAULT} state_t;

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
    if (RED_CYC + TOL_CYC > CNT_MAX || BLUE_CYC + TOL_CYC > CNT_MAX ||
        GREEN_CYC + TOL_CYC > CNT_MAX) begin : g_cnt_w_chk
        $error("light_phase_monitor: CNT_W cannot hold nominal + TOL_CYC");
    end

    function automatic state_t ph_state(input phase_t p);
        case (p)
            PH_RED:   return S_RED;
            PH_BLUE:  return S_BLUE;
            PH_GREEN: return S_GREEN;
            default:  return S_SYNC;
        endcase
    endfunction

    logic [2:0]       pat;
    logic             chg;
    state_t           state_q, state_d;
    phase_t           phase_q, phase_d, pat_ph, succ;
    logic             valid_q, valid_d, done_q, done_d, fault_q, fault_d;
    logic             partial_q, partial_d;
    logic [CNT_W-1:0] last_dur_q, last_dur_d, cnt_q, cnt_d;
    fault_code_t      code_q, code_d, raise_code;
    logic             raise, too_long, too_short;

    lamp_filter #(.FILT_CYC(FILT_CYC)) u_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .lamp_n ({bus.red_n, bus.green_n, bus.blue_n}),
        .pat    (pat),
        .chg    (chg)
    );

`ifdef LPM_DUR_CHECK_EN
    int nom;
    always_comb begin
        case (phase_q)
            PH_RED:   nom = RED_CYC;
            PH_BLUE:  nom = BLUE_CYC;
            PH_GREEN: nom = GREEN_CYC;
            default:  nom = 0;
        endcase
    end
    assign too_long  = !partial_q && (int'(cnt_q) > nom + TOL_CYC);
    assign too_short = !partial_q && (int'(cnt_q) < nom - TOL_CYC);
`else
    assign too_long  = 1'b0;
    assign too_short = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        last_dur_d = last_dur_q;
        fault_d    = fault_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        partial_d  = partial_q;
        raise      = 1'b0;
        raise_code = FC_NONE;
        pat_ph     = lamp_phase(pat);
        succ       = next_phase(phase_q);
        if (bus.clr_fault) begin
            state_d = S_SYNC;
            phase_d = PH_NONE;
            valid_d = 1'b0;
            fault_d = 1'b0;
            code_d  = FC_NONE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_SYNC: if (pat_ph != PH_NONE) begin
                    state_d   = ph_state(pat_ph);
                    phase_d   = pat_ph;
                    valid_d   = 1'b1;
                    cnt_d     = CNT_W'(1);
                    partial_d = 1'b1;
                end
                S_RED, S_BLUE, S_GREEN: begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    // LONG outranks a pattern change landing in the same cycle.
                    if (too_long) begin
                        raise = 1'b1; raise_code = FC_LONG;
                    end else if (chg) begin
                        if (pat_ph == succ) begin
                            last_dur_d = cnt_q;
                            done_d     = !partial_q;
                            if (too_short) begin
                                raise = 1'b1; raise_code = FC_SHORT;
                            end else begin
                                state_d   = ph_state(succ);
                                phase_d   = succ;
                                cnt_d     = CNT_W'(1);
                                partial_d = 1'b0;
                            end
                        end else if (pat == LAMP_DARK) begin
                            raise = 1'b1; raise_code = FC_DARK;
                        end else if (pat_ph == PH_NONE) begin
                            raise = 1'b1; raise_code = FC_ILLEGAL;
                        end else begin
                            raise = 1'b1; raise_code = FC_BAD_SEQ;
                        end
                    end
                end
                default: ;
            endcase
            if (raise) begin
                state_d = S_FAULT;
                phase_d = PH_NONE;
                valid_d = 1'b0;
                fault_d = 1'b1;
                code_d  = raise_code;
                cnt_d   = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_SYNC;
            phase_q    <= PH_NONE;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            last_dur_q <= '0;
            fault_q    <= 1'b0;
            code_q     <= FC_NONE;
            cnt_q      <= '0;
            partial_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            last_dur_q <= last_dur_d;
            fault_q    <= fault_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            partial_q  <= partial_d;
        end
    end

    assign bus.phase       = phase_q;
    assign bus.phase_valid = valid_q;
    assign bus.phase_done  = done_q;
    assign bus.last_dur    = last_dur_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;

endmodule

// File: tb/tb_light_phase_monitor.sv
// Scenario bench for light_phase_monitor: expected phase_done durations and fault codes
// are queued as lamp stimulus is driven and matched when the monitor reports them.
module tb_light_phase_monitor;
    localparam int CW = 8;
    localparam logic [2:0] P_R  = 3'b011;
    localparam logic [2:0] P_G  = 3'b101;
    localparam logic [2:0] P_B  = 3'b110;
    localparam logic [2:0] P_D  = 3'b111;
    localparam logic [2:0] P_RG = 3'b001;
    localparam logic [2:0] P_RB = 3'b010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fault_prev = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   done_q[$];
    int   fault_q[$];

    light_phase_monitor_if #(.CNT_W(CW)) bus ();

    light_phase_monitor #(
        .RED_CYC(20), .BLUE_CYC(4), .GREEN_CYC(10),
        .TOL_CYC(1), .FILT_CYC(2), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic lamps(input logic [2:0] p, input int n);
        {bus.red_n, bus.green_n, bus.blue_n} = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lamps(P_D, 3);
        rst_n = 1'b1;
    endtask

    task automatic pulse_clr();
        bus.clr_fault = 1'b1;
        @(negedge clk);
        bus.clr_fault = 1'b0;
    endtask

    task automatic drain(input string tag);
        chk({tag, "_done_left"}, done_q.size(), 0);
        chk({tag, "_fault_left"}, fault_q.size(), 0);
        done_q.delete();
        fault_q.delete();
    endtask

    // Scoreboard side: every done pulse / fault rise must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.phase_done) begin
                if (done_q.size() == 0) chk("unexpected_done", bus.phase_done, 0);
                else chk("last_dur", bus.last_dur, done_q.pop_front());
            end
            if (bus.fault && !fault_prev) begin
                if (fault_q.size() == 0) chk("unexpected_fault", bus.fault, 0);
                else chk("fault_code", bus.fault_code, fault_q.pop_front());
            end
        end
        fault_prev <= bus.fault;
    end

    initial begin
        bus.clr_fault = 1'b0;
        {bus.red_n, bus.green_n, bus.blue_n} = P_D;

        // Reset values, acquisition latency, clean cycle
        rst_n = 1'b0;
        lamps(P_D, 3);
        chk("rst_phase", bus.phase, 3);
        chk("rst_valid", bus.phase_valid, 0);
        chk("rst_done", bus.phase_done, 0);
        chk("rst_last_dur", bus.last_dur, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_code", bus.fault_code, 0);
        rst_n = 1'b1;
        lamps(P_R, 3);
        chk("acq_not_yet", bus.phase, 3);
        lamps(P_R, 5);
        chk("acq_phase", bus.phase, 0);
        chk("acq_valid", bus.phase_valid, 1);
        lamps(P_B, 4);
        done_q.push_back(4);
        lamps(P_G, 10);
        done_q.push_back(10);
        lamps(P_R, 20);
        done_q.push_back(20);
        lamps(P_B, 5);
        chk("clean_phase", bus.phase, 1);
        chk("clean_fault", bus.fault, 0);
        drain("clean");

        // BLUE held 2 cycles
        do_reset();
        lamps(P_R, 8);
        lamps(P_B, 2);
        done_q.push_back(2);
`ifdef LPM_DUR_CHECK_EN
        fault_q.push_back(3);
        lamps(P_G, 8);
        chk("short_fault", bus.fault, 1);
        chk("short_code", bus.fault_code, 3);
`else
        lamps(P_G, 8);
        chk("short_fault", bus.fault, 0);
        chk("short_phase", bus.phase, 2);
`endif
        drain("short");

        // GREEN overstays
        do_reset();
        lamps(P_R, 8);
        lamps(P_B, 4);
        done_q.push_back(4);
`ifdef LPM_DUR_CHECK_EN
        fault_q.push_back(4);
`endif
        lamps(P_G, 15);
        chk("long_not_yet", bus.fault, 0);
        lamps(P_G, 1);
`ifdef LPM_DUR_CHECK_EN
        chk("long_fault", bus.fault, 1);
        chk("long_code", bus.fault_code, 4);
`else
        chk("long_fault", bus.fault, 0);
        chk("long_phase", bus.phase, 2);
`endif
        drain("long");

        // RED->GREEN skip, then multi-lamp, then clear
        do_reset();
        lamps(P_R, 8);
        fault_q.push_back(2);
        lamps(P_G, 6);
        chk("skip_code", bus.fault_code, 2);
        chk("skip_phase", bus.phase, 3);
        chk("skip_valid", bus.phase_valid, 0);
        lamps(P_RG, 6);
        chk("first_only_code", bus.fault_code, 2);
        pulse_clr();
        chk("clr_fault", bus.fault, 0);
        chk("clr_code", bus.fault_code, 0);
        chk("clr_valid", bus.phase_valid, 0);
        lamps(P_RG, 4);
        chk("clr_illegal_valid", bus.phase_valid, 0);
        lamps(P_B, 3);
        chk("relock_not_yet", bus.phase_valid, 0);
        lamps(P_B, 1);
        chk("relock_valid", bus.phase_valid, 1);
        chk("relock_phase", bus.phase, 1);
        drain("skip");

        // Glitch rejection, then dark
        do_reset();
        lamps(P_R, 8);
        lamps(P_RB, 1);
        lamps(P_R, 8);
        chk("glitch_phase", bus.phase, 0);
        chk("glitch_fault", bus.fault, 0);
        fault_q.push_back(5);
        lamps(P_D, 3);
        lamps(P_R, 6);
        chk("dark_code", bus.fault_code, 5);
        drain("dark");

        // Async reset mid-GREEN, then the next phase is partial
        do_reset();
        lamps(P_R, 8);
        lamps(P_B, 4);
        done_q.push_back(4);
        lamps(P_G, 5);
        rst_n = 1'b0;
        #1;
        chk("arst_phase", bus.phase, 3);
        chk("arst_valid", bus.phase_valid, 0);
        chk("arst_last_dur", bus.last_dur, 0);
        chk("arst_code", bus.fault_code, 0);
        @(negedge clk);
        rst_n = 1'b1;
        lamps(P_G, 6);
        chk("arst_relock", bus.phase, 2);
        lamps(P_R, 6);
        chk("arst_next_phase", bus.phase, 0);
        drain("arst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
